reg_wb_queue: RTL and testbench
===============================

// Module: reg_wb_queue
// PURPOSE
// - Write-back queue feeding the register file's single write port.
// - Accepts register writes from execute/memory with valid/ready, buffers them in order, and drains at most one per cycle.
// - Gives forwarding lookups so the read stage sees writes that are still pending.
// - Sits between the pipeline write-back producers and the register file.
// PARAMETERS
// - DEPTH  4   queue entries; power of 2, >=2
// - AW     5   register address width
// - DW     32  register data width
// PORTS
// - clk      in   1            clock; all state updates on the rising edge
// - rst_n    in   1            reset, asynchronous, active-low
// - in_valid in   1            producer has a write to enqueue
// - in_ready out  1            queue can accept; equals !full
// - in_addr  in   AW           destination register
// - in_data  in   DW           write data
// - wb_hold  in   1            1 = do not drain this cycle
// - rf_wr    out  1            register file write enable (registered)
// - rf_addr  out  AW           register file write address (registered)
// - rf_din   out  DW           register file write data (registered)
// - q_addr1  in   AW           forwarding lookup address, read port 1
// - q_addr2  in   AW           forwarding lookup address, read port 2
// - q_hit1   out  1            a pending write to q_addr1 exists
// - q_hit2   out  1            a pending write to q_addr2 exists
// - q_data1  out  DW           youngest pending data for q_addr1; 0 when no hit
// - q_data2  out  DW           youngest pending data for q_addr2; 0 when no hit
// - count    out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
// - Reset (async, immediate):
//   - head/tail pointers, count, rf_wr, rf_addr and rf_din all go to 0.
//   - in_ready goes to 1.
// - Push:
//   - A push happens when in_valid && in_ready at the edge.
//   - The entry is written at the tail; the tail pointer wraps modulo DEPTH.
// - Pop:
//   - At each edge where !wb_hold && count!=0, the head entry loads rf_addr/rf_din, rf_wr goes to 1, and the head wraps modulo DEPTH.
//   - Otherwise rf_wr goes to 0 and rf_addr/rf_din hold their values.
// - Latency:
//   - A push accepted at edge E0 drives rf_wr=1 after E1.
//   - The register file captures the write at E2.
// - Push and pop in the same edge:
//   - count is unchanged.
//   - in_ready is based on the count at the start of the cycle, so a full queue stays not-ready even while popping.
// - Full/empty:
//   - count==DEPTH: in_ready=0 and in_valid is ignored.
//   - count==0: no pop and rf_wr=0.
// - Forwarding (combinational):
//   - Searches the rf_* output register when rf_wr=1, plus every valid queue entry.
//   - The youngest match wins: the queue tail side has priority over the head side, which has priority over the output register.
//   - A lookup sees an entry from the cycle after its push edge.
// - Order: writes reach the register file in exactly push order, including repeated writes to the same address.
// - Arithmetic: pointers are log2(DEPTH) bits and wrap naturally; count is one bit wider.
// CONFIGURATION
// - WB_ZERO_FILTER_EN defined:
//   - A push with in_addr==0 is accepted (handshake completes) but not stored; count is unchanged.
//   - A lookup of address 0 always gives hit=0, data=0.
// - WB_ZERO_FILTER_EN undefined:
//   - Address 0 is queued, forwarded and written like any other address.
// TESTING
// - Reset, then push (3,0x11) with wb_hold=0 -> rf_wr=1, rf_addr=3, rf_din=0x11 one cycle after the push edge; count back to 0.
// - wb_hold=1, push (1,A) (2,B) (3,C) (4,D) -> count=4, in_ready=0, 5th push stalls; release hold -> 4 consecutive rf_wr cycles in order 1,2,3,4.
// - wb_hold=1, push (5,0xA) then (5,0xB), q_addr1=5, q_addr2=6 -> q_hit1=1, q_data1=0xB, q_hit2=0, q_data2=0.
// - count=2, push and pop on the same edge -> count stays 2, then rf_wr=1 with the old head entry.
// - Push (0,0x55) -> with WB_ZERO_FILTER_EN: count stays 0, no rf_wr, q_hit for address 0 = 0; without it: rf_wr=1, rf_addr=0.
// - Fill 3 entries, deassert rst_n mid-drain -> rf_wr=0 and count=0 immediately; after release, a new push drains normally.

Source files
------------

// File: rtl/reg_wb_queue.sv
// In-order write-back queue for the register file's single write port, with two forwarding lookups.
// Optional WB_ZERO_FILTER_EN: writes to register 0 are accepted but dropped, and lookups of register 0 never hit.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     wb_hold,
  output logic                     rf_wr,
  output logic [AW-1:0]            rf_addr,
  output logic [DW-1:0]            rf_din,
  input  logic [AW-1:0]            q_addr1,
  input  logic [AW-1:0]            q_addr2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [DW-1:0]            q_data1,
  output logic [DW-1:0]            q_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          store;
  logic          pop;
  logic [PW-1:0] idx;

  // Readiness comes from the registered count, so a full queue stays closed even on a draining edge.
  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = !wb_hold && (count != '0);

`ifdef WB_ZERO_FILTER_EN
  assign store = push && (in_addr != '0);
`else
  assign store = push;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rf_wr   <= 1'b0;
      rf_addr <= '0;
      rf_din  <= '0;
    end else begin
      if (store) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head    <= head + 1'b1;
        rf_addr <= mem_addr[head];
        rf_din  <= mem_data[head];
      end
      rf_wr <= pop;
      count <= count + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_addr[tail] <= in_addr;
      mem_data[tail] <= in_data;
    end
  end

  // Walk from oldest to youngest so the last match found is the youngest pending write.
  always_comb begin
    q_hit1  = 1'b0;
    q_hit2  = 1'b0;
    q_data1 = '0;
    q_data2 = '0;
    idx     = '0;
    if (rf_wr && (rf_addr == q_addr1)) begin
      q_hit1  = 1'b1;
      q_data1 = rf_din;
    end
    if (rf_wr && (rf_addr == q_addr2)) begin
      q_hit2  = 1'b1;
      q_data2 = rf_din;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (CW'(k) < count) begin
        if (mem_addr[idx] == q_addr1) begin
          q_hit1  = 1'b1;
          q_data1 = mem_data[idx];
        end
        if (mem_addr[idx] == q_addr2) begin
          q_hit2  = 1'b1;
          q_data2 = mem_data[idx];
        end
      end
    end
`ifdef WB_ZERO_FILTER_EN
    if (q_addr1 == '0) begin
      q_hit1  = 1'b0;
      q_data1 = '0;
    end
    if (q_addr2 == '0) begin
      q_hit2  = 1'b0;
      q_data2 = '0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed self-checking bench for reg_wb_queue (DEPTH=4, AW=5, DW=32); follows WB_ZERO_FILTER_EN if defined.
module tb_reg_wb_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_din;
  logic [4:0]  q_addr1;
  logic [4:0]  q_addr2;
  logic        q_hit1;
  logic        q_hit2;
  logic [31:0] q_data1;
  logic [31:0] q_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  reg_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wb_hold(wb_hold),
    .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_din(rf_din),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d, input logic h);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    wb_hold  = h;
  endtask

  // Inputs change on the falling edge, outputs are checked there one edge after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    q_addr1 = 5'd0;
    q_addr2 = 5'd0;
    #12;
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_rf_wr", 64'(rf_wr), 64'd0);
    checkOutput("rst_rf_addr", 64'(rf_addr), 64'd0);
    checkOutput("rst_rf_din", 64'(rf_din), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // single write passes straight through
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b0);
    q_addr1 = 5'd3;
    stepCycle();
    checkOutput("t1_count_after_push", 64'(count), 64'd1);
    checkOutput("t1_rf_wr_not_yet", 64'(rf_wr), 64'd0);
    checkOutput("t1_fwd_queue_hit", 64'(q_hit1), 64'd1);
    checkOutput("t1_fwd_queue_data", 64'(q_data1), 64'h11);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("t1_rf_wr", 64'(rf_wr), 64'd1);
    checkOutput("t1_rf_addr", 64'(rf_addr), 64'd3);
    checkOutput("t1_rf_din", 64'(rf_din), 64'h11);
    checkOutput("t1_count_drained", 64'(count), 64'd0);
    checkOutput("t1_fwd_rf_hit", 64'(q_hit1), 64'd1);
    stepCycle();
    checkOutput("t1_rf_wr_low", 64'(rf_wr), 64'd0);
    checkOutput("t1_rf_addr_hold", 64'(rf_addr), 64'd3);
    checkOutput("t1_fwd_idle_hit", 64'(q_hit1), 64'd0);

    // fill to full under hold, then drain in order while a stalled push is offered
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 5'(i), 32'hA0 + 32'(i), 1'b1);
      stepCycle();
    end
    checkOutput("t2_count_full", 64'(count), 64'd4);
    checkOutput("t2_in_ready_full", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 5'd5, 32'hEE, 1'b1);
    stepCycle();
    checkOutput("t2_count_stalled", 64'(count), 64'd4);
    q_addr1 = 5'd1;
    q_addr2 = 5'd4;
    #1;
    checkOutput("t2_fwd_oldest", 64'(q_data1), 64'hA1);
    checkOutput("t2_fwd_youngest", 64'(q_data2), 64'hA4);
    applyStimulus(1'b1, 5'd5, 32'hEE, 1'b0);
    stepCycle();
    checkOutput("t2_pop1_rf_wr", 64'(rf_wr), 64'd1);
    checkOutput("t2_pop1_addr", 64'(rf_addr), 64'd1);
    checkOutput("t2_pop1_din", 64'(rf_din), 64'hA1);
    checkOutput("t2_pop1_count", 64'(count), 64'd3);
    checkOutput("t2_ready_again", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 2; i <= 4; i++) begin
      stepCycle();
      checkOutput($sformatf("t2_pop%0d_rf_wr", i), 64'(rf_wr), 64'd1);
      checkOutput($sformatf("t2_pop%0d_addr", i), 64'(rf_addr), 64'(i));
      checkOutput($sformatf("t2_pop%0d_din", i), 64'(rf_din), 64'hA0 + 64'(i));
    end
    checkOutput("t2_count_empty", 64'(count), 64'd0);
    stepCycle();
    checkOutput("t2_no_fifth_write", 64'(rf_wr), 64'd0);

    // youngest duplicate wins, then push and pop on one edge
    applyStimulus(1'b1, 5'd5, 32'hA, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 5'd5, 32'hB, 1'b1);
    stepCycle();
    q_addr1 = 5'd5;
    q_addr2 = 5'd6;
    #1;
    checkOutput("t3_hit1", 64'(q_hit1), 64'd1);
    checkOutput("t3_data1", 64'(q_data1), 64'hB);
    checkOutput("t3_hit2", 64'(q_hit2), 64'd0);
    checkOutput("t3_data2", 64'(q_data2), 64'd0);
    q_addr2 = 5'd7;
    applyStimulus(1'b1, 5'd7, 32'hC, 1'b0);
    stepCycle();
    checkOutput("t3_pushpop_count", 64'(count), 64'd2);
    checkOutput("t3_pushpop_rf_wr", 64'(rf_wr), 64'd1);
    checkOutput("t3_pushpop_addr", 64'(rf_addr), 64'd5);
    checkOutput("t3_pushpop_din", 64'(rf_din), 64'hA);
    checkOutput("t3_queue_over_rf", 64'(q_data1), 64'hB);
    checkOutput("t3_fwd_new_entry", 64'(q_data2), 64'hC);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("t3_pop_b_din", 64'(rf_din), 64'hB);
    checkOutput("t3_fwd_from_rf", 64'(q_data1), 64'hB);
    stepCycle();
    checkOutput("t3_pop_c_addr", 64'(rf_addr), 64'd7);
    checkOutput("t3_pop_c_din", 64'(rf_din), 64'hC);
    checkOutput("t3_count_empty", 64'(count), 64'd0);
    stepCycle();

    // writes to register 0
    applyStimulus(1'b1, 5'd0, 32'h55, 1'b0);
    q_addr1 = 5'd0;
    stepCycle();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
`ifdef WB_ZERO_FILTER_EN
    checkOutput("t4_zero_count", 64'(count), 64'd0);
    checkOutput("t4_zero_hit", 64'(q_hit1), 64'd0);
    stepCycle();
    checkOutput("t4_zero_no_write", 64'(rf_wr), 64'd0);
    checkOutput("t4_zero_hit_after", 64'(q_hit1), 64'd0);
`else
    checkOutput("t4_zero_count", 64'(count), 64'd1);
    checkOutput("t4_zero_hit", 64'(q_hit1), 64'd1);
    checkOutput("t4_zero_data", 64'(q_data1), 64'h55);
    stepCycle();
    checkOutput("t4_zero_rf_wr", 64'(rf_wr), 64'd1);
    checkOutput("t4_zero_rf_addr", 64'(rf_addr), 64'd0);
    checkOutput("t4_zero_rf_din", 64'(rf_din), 64'h55);
`endif
    stepCycle();

    // asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(8 + i), 32'(i + 1), 1'b1);
      stepCycle();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("t5_drain_rf_addr", 64'(rf_addr), 64'd8);
    checkOutput("t5_drain_count", 64'(count), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_rf_wr", 64'(rf_wr), 64'd0);
    checkOutput("t5_async_count", 64'(count), 64'd0);
    checkOutput("t5_async_rf_addr", 64'(rf_addr), 64'd0);
    checkOutput("t5_async_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd11, 32'h77, 1'b0);
    stepCycle();
    checkOutput("t5_post_count", 64'(count), 64'd1);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    stepCycle();
    checkOutput("t5_post_rf_wr", 64'(rf_wr), 64'd1);
    checkOutput("t5_post_rf_addr", 64'(rf_addr), 64'd11);
    checkOutput("t5_post_rf_din", 64'(rf_din), 64'h77);
    checkOutput("t5_post_count_empty", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
